// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scan_pkg
//  Purpose  : Shared types and constants for the decoder scan controller.
//  Revision : 1.0  initial release
// ============================================================================
package scan_pkg;

    localparam int NUM_LINES = 8;
    localparam int SEL_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

endpackage : scan_pkg
`default_nettype wire

// File: rtl/mask_next_idx.sv
`default_nettype none
// ============================================================================
//  Module   : mask_next_idx
//  Purpose  : Rotating priority finder. Returns the first set mask bit strictly
//             above cur, wrapping modulo NUM_LINES (cur itself is tried last).
//             wrap flags that the result is at or below cur; none flags an
//             empty mask.
//  Revision : 1.0  initial release
// ============================================================================
module mask_next_idx
    import scan_pkg::*;
(
    input  logic [NUM_LINES-1:0] mask,
    input  logic [SEL_W-1:0]     cur,
    output logic [SEL_W-1:0]     nxt,
    output logic                 wrap,
    output logic                 none
);

    logic [SEL_W-1:0] w_probe;
    logic             w_found;

    // Search upward from cur+1, taking the first set bit found
    always_comb begin
        nxt     = cur;
        w_found = 1'b0;
        w_probe = '0;
        for (int k = 1; k <= NUM_LINES; k++) begin
            w_probe = cur + SEL_W'(k);
            if (!w_found && mask[w_probe]) begin
                nxt     = w_probe;
                w_found = 1'b1;
            end
        end
    end

    assign none = ~|mask;
    assign wrap = ~none & (nxt <= cur);

endmodule : mask_next_idx
`default_nettype wire

// File: rtl/decoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_scan_ctrl
//  Purpose  : Sequencer feeding a 3-to-8 decoder. Steps through the lines set
//             in a shadowed mask, holds each for a programmable dwell and
//             inserts a blanking gap so that sel only moves while sel_en is low.
//  Revision : 1.0  initial release
// ============================================================================
module decoder_scan_ctrl
    import scan_pkg::*;
#(
    parameter int DWELL_W   = 16,
    parameter int BLANK_CYC = 2
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [NUM_LINES-1:0] mask,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [SEL_W-1:0]     sel,
    output logic                 sel_en,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int                 c_BCNT_W    = (BLANK_CYC > 2) ? $clog2(BLANK_CYC) : 1;
    localparam logic [c_BCNT_W-1:0] c_BCNT_LOAD = c_BCNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam bit                 c_NO_BLANK  = (BLANK_CYC == 0);
    localparam logic [SEL_W-1:0]   c_LAST_IDX  = SEL_W'(NUM_LINES - 1);

    // Dwell of 0 behaves as 1; counter runs from dwell-1 down to 0
    function automatic logic [DWELL_W-1:0] f_dwell_load(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

    scan_state_t            r_state;
    logic [SEL_W-1:0]       r_sel;
    logic                   r_sel_en;
    logic                   r_frame_done;
    logic                   r_busy;
    logic                   r_pend;
    logic [NUM_LINES-1:0]   r_mask_sh;
    logic [DWELL_W-1:0]     r_dwell_sh;
    logic [c_BCNT_W-1:0]    r_bcnt;
    logic [DWELL_W-1:0]     r_dcnt;

    scan_state_t            w_state_nxt;
    logic [SEL_W-1:0]       w_sel_nxt;
    logic                   w_sel_en_nxt;
    logic                   w_frame_done_nxt;
    logic                   w_busy_nxt;
    logic                   w_pend_nxt;
    logic [NUM_LINES-1:0]   w_mask_sh_nxt;
    logic [DWELL_W-1:0]     w_dwell_sh_nxt;
    logic [c_BCNT_W-1:0]    w_bcnt_nxt;
    logic [DWELL_W-1:0]     w_dcnt_nxt;

    logic [SEL_W-1:0]       w_first_idx;
    logic                   w_first_wrap;
    logic                   w_first_none;
    logic [SEL_W-1:0]       w_step_idx;
    logic                   w_step_wrap;
    logic                   w_step_none;
    logic                   w_frame_wrap;

    // First line of a frame, searched in the live mask input from bit 0
    mask_next_idx u_first (
        .mask (mask),
        .cur  (c_LAST_IDX),
        .nxt  (w_first_idx),
        .wrap (w_first_wrap),
        .none (w_first_none)
    );

    // Next line within the current frame, searched in the shadow mask
    mask_next_idx u_step (
        .mask (r_mask_sh),
        .cur  (r_sel),
        .nxt  (w_step_idx),
        .wrap (w_step_wrap),
        .none (w_step_none)
    );

    assign w_frame_wrap = w_step_wrap | w_step_none;

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_sel_en     <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_pend       <= 1'b0;
            r_mask_sh    <= '0;
            r_dwell_sh   <= '0;
            r_bcnt       <= '0;
            r_dcnt       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_sel_en     <= w_sel_en_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_busy       <= w_busy_nxt;
            r_pend       <= w_pend_nxt;
            r_mask_sh    <= w_mask_sh_nxt;
            r_dwell_sh   <= w_dwell_sh_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_dcnt       <= w_dcnt_nxt;
        end
    end

    // Next state, next line index, counters and frame-boundary relatch
    always_comb begin
        w_state_nxt      = r_state;
        w_sel_nxt        = r_sel;
        w_frame_done_nxt = 1'b0;
        w_pend_nxt       = r_pend;
        w_mask_sh_nxt    = r_mask_sh;
        w_dwell_sh_nxt   = r_dwell_sh;
        w_bcnt_nxt       = r_bcnt;
        w_dcnt_nxt       = r_dcnt;

        case (r_state)
            IDLE: begin
                if (start && !stop && w_first_wrap) begin
                    w_mask_sh_nxt  = mask;
                    w_dwell_sh_nxt = dwell;
                    w_sel_nxt      = w_first_idx;
                    w_pend_nxt     = 1'b0;
                    if (c_NO_BLANK) begin
                        w_state_nxt = DRIVE;
                        w_dcnt_nxt  = f_dwell_load(dwell);
                    end else begin
                        w_state_nxt = BLANK;
                        w_bcnt_nxt  = c_BCNT_LOAD;
                    end
                end
            end

            BLANK: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                    w_pend_nxt  = 1'b0;
                end else if (r_bcnt == '0) begin
                    w_state_nxt = DRIVE;
                    w_dcnt_nxt  = f_dwell_load(r_dwell_sh);
                end else begin
                    w_bcnt_nxt = r_bcnt - c_BCNT_W'(1);
                end
            end

            DRIVE: begin
                if (stop) begin
                    w_pend_nxt = 1'b1;
                end
                if (r_dcnt == '0) begin
                    // Shadow registers only move at the frame boundary
                    if (w_frame_wrap) begin
                        w_mask_sh_nxt    = mask;
                        w_dwell_sh_nxt   = dwell;
                        w_frame_done_nxt = 1'b1;
                    end
                    if (r_pend || stop) begin
                        w_state_nxt = IDLE;
                        w_pend_nxt  = 1'b0;
                    end else if (w_frame_wrap && w_first_none) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_sel_nxt = w_frame_wrap ? w_first_idx : w_step_idx;
                        if (c_NO_BLANK) begin
                            w_state_nxt = DRIVE;
                            w_dcnt_nxt  = f_dwell_load(w_frame_wrap ? dwell : r_dwell_sh);
                        end else begin
                            w_state_nxt = BLANK;
                            w_bcnt_nxt  = c_BCNT_LOAD;
                        end
                    end
                end else begin
                    w_dcnt_nxt = r_dcnt - DWELL_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from the state being entered
    always_comb begin
        w_sel_en_nxt = (w_state_nxt == DRIVE);
        w_busy_nxt   = (w_state_nxt != IDLE);
    end

    assign sel        = r_sel;
    assign sel_en     = r_sel_en;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule : decoder_scan_ctrl
`default_nettype wire

// File: tb/tb_decoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_scan_ctrl
//  Purpose  : Self-checking bench for decoder_scan_ctrl. Expected lines are
//             queued as stimulus is applied and checked as the DUT drives them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decoder_scan_ctrl;

    localparam int DWELL_W   = 16;
    localparam int BLANK_CYC = 2;

    logic                clk   = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                stop  = 1'b0;
    logic [7:0]          mask  = '0;
    logic [DWELL_W-1:0]  dwell = '0;
    logic [2:0]          sel;
    logic                sel_en;
    logic                frame_done;
    logic                busy;

    decoder_scan_ctrl #(
        .DWELL_W   (DWELL_W),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .mask       (mask),
        .dwell      (dwell),
        .sel        (sel),
        .sel_en     (sel_en),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        int         dwell;
        bit         wrap;
    } item_t;

    item_t exp_q[$];
    item_t cur_item;
    int    vectors     = 0;
    int    miscompares = 0;
    bit    prev_en     = 1'b0;
    bit    have_cur    = 1'b0;
    bit    sel_chg     = 1'b0;
    int    run_lo      = 0;
    int    run_hi      = 0;

    // Scoreboard monitor: pop an expected line when sel_en rises, check the
    // blank gap before it, its dwell length, sel stability and frame_done.
    always @(negedge clk) begin
        if (reset) begin
            prev_en  = 1'b0;
            have_cur = 1'b0;
            sel_chg  = 1'b0;
            run_lo   = 0;
            run_hi   = 0;
        end else begin
            if (sel_en && !prev_en) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    have_cur = 1'b0;
                    $display("FAIL line_unexpected: sel_en rose with sel=%0d, no line expected", sel);
                end else begin
                    cur_item = exp_q.pop_front();
                    have_cur = 1'b1;
                    if (sel !== cur_item.sel) begin
                        miscompares++;
                        $display("FAIL line_sel: got sel=%0d want %0d", sel, cur_item.sel);
                    end
                end
                vectors++;
                if (run_lo != BLANK_CYC) begin
                    miscompares++;
                    $display("FAIL line_blank: got %0d blank cycles want %0d", run_lo, BLANK_CYC);
                end
                run_hi  = 1;
                sel_chg = 1'b0;
            end else if (sel_en) begin
                run_hi++;
                if (have_cur && sel !== cur_item.sel) sel_chg = 1'b1;
            end

            if (!sel_en && prev_en) begin
                if (have_cur) begin
                    vectors++;
                    if (run_hi != cur_item.dwell) begin
                        miscompares++;
                        $display("FAIL line_dwell: sel=%0d got %0d cycles want %0d", cur_item.sel, run_hi, cur_item.dwell);
                    end
                    vectors++;
                    if (frame_done !== cur_item.wrap) begin
                        miscompares++;
                        $display("FAIL frame_done_edge: after sel=%0d got %0b want %0b", cur_item.sel, frame_done, cur_item.wrap);
                    end
                    vectors++;
                    if (sel_chg) begin
                        miscompares++;
                        $display("FAIL sel_stable: sel moved during drive of line %0d, got 1 want 0", cur_item.sel);
                    end
                end
                have_cur = 1'b0;
            end else begin
                vectors++;
                if (frame_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL frame_done_spurious: got %0b want 0", frame_done);
                end
            end

            run_lo  = (busy && !sel_en) ? run_lo + 1 : 0;
            prev_en = sel_en;
        end
    end

    task automatic push(input logic [2:0] s, input int d, input bit w);
        item_t it;
        it.sel   = s;
        it.dwell = d;
        it.wrap  = w;
        exp_q.push_back(it);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    // Wait until the expected-line queue has drained to the given depth
    task automatic wait_q_level(input int level, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() <= level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Wait until busy drops; n returns the number of cycles taken
    task automatic wait_idle(input int budget, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            n++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (sel !== 3'd0) begin miscompares++; $display("FAIL reset_sel: got %0d want 0", sel); end
        vectors++;
        if (sel_en !== 1'b0) begin miscompares++; $display("FAIL reset_sel_en: got %0b want 0", sel_en); end
        vectors++;
        if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
        reset = 1'b0;
    endtask

    task automatic test_full_scan();
        bit ok;
        int n;
        int busy_low = 0;
        mask  = 8'hFF;
        dwell = 16'd3;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++) push(3'(i), 3, i == 7);
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #1;
            if (!busy) busy_low++;
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL full_scan_timeout: %0d lines outstanding want 0", exp_q.size()); end
        vectors++;
        if (busy_low != 0) begin miscompares++; $display("FAIL full_scan_busy: got %0d idle cycles want 0", busy_low); end
        pulse_stop();
        wait_idle(20, ok, n);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL full_scan_stop: busy still 1 want 0"); end
        vectors++;
        if (sel !== 3'd7) begin miscompares++; $display("FAIL full_scan_sel_hold: got %0d want 7", sel); end
    endtask

    task automatic test_sparse();
        bit ok;
        int n;
        mask  = 8'b1001_0010;
        dwell = 16'd1;
        for (int f = 0; f < 2; f++) begin
            push(3'd1, 1, 1'b0);
            push(3'd4, 1, 1'b0);
            push(3'd7, 1, 1'b1);
        end
        pulse_start();
        wait_q_level(0, 100, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL sparse_timeout: %0d lines outstanding want 0", exp_q.size()); end
        pulse_stop();
        wait_idle(20, ok, n);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL sparse_stop: busy still 1 want 0"); end
    endtask

    task automatic test_dwell_zero();
        bit ok;
        int n;
        mask  = 8'h20;
        dwell = 16'd0;
        for (int i = 0; i < 3; i++) push(3'd5, 1, 1'b1);
        pulse_start();
        wait_q_level(0, 60, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL dwell_zero_timeout: %0d lines outstanding want 0", exp_q.size()); end
        pulse_stop();
        wait_idle(20, ok, n);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL dwell_zero_stop: busy still 1 want 0"); end
    endtask

    task automatic test_mask_change();
        bit ok;
        int n;
        mask  = 8'hFF;
        dwell = 16'd2;
        for (int i = 0; i < 8; i++) push(3'(i), 2, i == 7);
        for (int i = 0; i < 3; i++) push(3'd0, 2, 1'b1);
        pulse_start();
        wait_q_level(7, 100, ok);
        vectors++;
        if (!ok || sel !== 3'd3) begin miscompares++; $display("FAIL mask_change_sync: got sel=%0d want 3", sel); end
        mask = 8'h01;
        wait_q_level(0, 200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL mask_change_timeout: %0d lines outstanding want 0", exp_q.size()); end
        pulse_stop();
        wait_idle(20, ok, n);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL mask_change_stop: busy still 1 want 0"); end
    endtask

    task automatic test_stop_mid_dwell();
        bit ok;
        int n;
        int hit3 = 0;
        mask  = 8'hFF;
        dwell = 16'd5;
        push(3'd0, 5, 1'b0);
        push(3'd1, 5, 1'b0);
        push(3'd2, 5, 1'b0);
        pulse_start();
        wait_q_level(0, 100, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL stop_mid_timeout: %0d lines outstanding want 0", exp_q.size()); end
        @(posedge clk);
        #1;
        pulse_stop();
        wait_idle(20, ok, n);
        vectors++;
        if (!ok || n != 4) begin miscompares++; $display("FAIL stop_mid_latency: idle after %0d cycles want 4", n); end
        vectors++;
        if (sel_en !== 1'b0) begin miscompares++; $display("FAIL stop_mid_sel_en: got %0b want 0", sel_en); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (sel === 3'd3 || busy) hit3++;
        end
        vectors++;
        if (hit3 != 0 || sel !== 3'd2) begin miscompares++; $display("FAIL stop_mid_sel_hold: got sel=%0d bad=%0d want sel=2 bad=0", sel, hit3); end
    endtask

    task automatic test_async_reset();
        bit ok;
        int n;
        mask  = 8'hFF;
        dwell = 16'd4;
        for (int i = 0; i < 6; i++) push(3'(i), 4, 1'b0);
        pulse_start();
        wait_q_level(0, 100, ok);
        vectors++;
        if (!ok || sel !== 3'd5 || sel_en !== 1'b1) begin miscompares++; $display("FAIL async_reset_setup: got sel=%0d sel_en=%0b want 5/1", sel, sel_en); end
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (sel !== 3'd0 || sel_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_outputs: got sel=%0d sel_en=%0b busy=%0b fd=%0b want 0/0/0/0", sel, sel_en, busy, frame_done);
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
        push(3'd0, 4, 1'b0);
        push(3'd1, 4, 1'b0);
        pulse_start();
        wait_q_level(0, 60, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL async_reset_resume: %0d lines outstanding want 0", exp_q.size()); end
        pulse_stop();
        wait_idle(20, ok, n);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL async_reset_stop: busy still 1 want 0"); end
    endtask

    task automatic test_ignored_start();
        int bad = 0;
        mask  = 8'h00;
        dwell = 16'd2;
        pulse_start();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (busy || sel_en) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL start_zero_mask: got %0d active cycles want 0", bad); end
        bad  = 0;
        mask = 8'hFF;
        @(negedge clk);
        #1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (busy || sel_en) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL start_with_stop: got %0d active cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_sparse();
        test_dwell_zero();
        test_mask_change();
        test_stop_mid_dwell();
        test_async_reset();
        test_ignored_start();
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL queue_drain: %0d lines outstanding want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, bench still running want finished");
        $fatal(1, "watchdog");
    end

endmodule : tb_decoder_scan_ctrl
`default_nettype wire

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
Upstream sequencer for the 3-to-8 decoder. It produces the 3-bit select code and the enable that drive a time-multiplexed 8-line load, such as digit strobes of a multiplexed display. It steps through the active lines in a programmable mask, holds each line for a programmable dwell time, and inserts a fixed blanking gap between lines. A blanking gap holds enable low while the select code changes, so two lines are never strobed at once.

Parameters:
DWELL_W, 16, width of the dwell-count input.
BLANK_CYC, 2, number of enable-low cycles before each line is driven; 0 means no gap.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  level-sampled request to begin scanning; ignored while busy.
stop  input  1  level-sampled request to end scanning.
mask  input  8  line-enable mask; bit i=1 means line i is scanned.
dwell  input  DWELL_W  cycles each line is held enabled; value 0 is treated as 1.
sel  output  3  line index to the decoder's in input.
sel_en  output  1  decoder enable (e); high only in DRIVE.
frame_done  output  1  one-cycle pulse marking each wrap of the scan.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset, asserted asynchronously at any time including mid-scan:
  - state=IDLE; sel=0, sel_en=0, frame_done=0, busy=0.
  - Internal counters, shadow mask/dwell and pending-stop flag cleared.
- States: IDLE, BLANK, DRIVE.
- Outputs are registered, so each output reflects the state entered at that clock edge.
- IDLE:
  - start=1, stop=0, mask!=0: latch mask and dwell into shadow registers; set sel to the lowest set bit of the mask; busy=1; go to BLANK.
  - If BLANK_CYC=0, go straight to DRIVE instead of BLANK.
  - start with mask==0, or start together with stop: remain in IDLE, no output change.
- BLANK:
  - sel_en=0; sel already holds the target index.
  - Count BLANK_CYC cycles, then go to DRIVE.
  - stop=1 in BLANK: go to IDLE on the next edge; sel is held, busy=0.
- DRIVE:
  - sel_en=1 for max(dwell_shadow,1) consecutive cycles; sel stays stable throughout.
  - stop=1 during DRIVE sets the pending-stop flag; the current dwell is never truncated.
  - On the last dwell cycle, choose the next set bit strictly above the current index, wrapping modulo 8 with rotating priority.
- Wrap detection (next index <= current index, including a mask with a single set bit):
  - Relatch mask and dwell from the inputs; the shadow registers change only at this frame boundary.
  - Assert frame_done for exactly one cycle, coincident with the first cycle after DRIVE.
  - If the new mask is 0, go to IDLE; frame_done still pulses.
- After DRIVE ends:
  - If the pending-stop flag is set, go to IDLE: sel_en=0, busy=0, flag cleared.
  - Otherwise go to BLANK, or to DRIVE when BLANK_CYC=0, with sel updated to the next index.
- Changes to the mask or dwell inputs mid-frame have no effect until the next wrap.
- Dwell counter:
  - Width DWELL_W, loaded with dwell-1, decremented to 0.
  - No overflow: the maximum dwell is 2^DWELL_W-1 cycles.
- The invariant that sel changes only while sel_en=0 holds whenever BLANK_CYC>=1.

Decomposition:
- Shared package scan_pkg holds:
  - the state enum type (IDLE, BLANK, DRIVE);
  - constant NUM_LINES=8;
  - constant SEL_W=3.
- One natural sub-module, mask_next_idx: a combinational rotating priority finder.
  - Inputs: mask[7:0], cur[2:0].
  - Outputs: nxt[2:0], wrap, none.
  - Used both for the first index from IDLE (cur taken as 7, so the search starts at bit 0) and for stepping.

Test Plan:
- BLANK_CYC=2, dwell=3, mask=8'hFF, start pulsed one cycle → sel runs 0..7; each line has sel_en low 2 cycles then high 3 cycles; frame_done pulses every 40 cycles; busy stays 1.
- mask=8'b1001_0010, dwell=1 → sel sequence 1,4,7,1,4,7…; frame_done pulses once per 3 lines; lines 0, 2, 3, 5, 6 never selected.
- Change mask from 8'hFF to 8'h01 while sel=3 → lines 4..7 are still scanned; after the wrap only sel=0 repeats and frame_done pulses every line period.
- Assert stop during the 2nd of 5 dwell cycles on line 2 → sel_en stays high the remaining 3 cycles, then sel_en=0 and busy=0 the next cycle; sel is never driven to 3.
- Assert reset while in DRIVE on line 5 → sel=0, sel_en=0, busy=0 immediately with no clock edge; a later start resumes from the lowest set bit.
- start with mask=0, then start and stop together with mask=8'hFF → busy stays 0 and sel_en stays 0 throughout.
